// File: rtl/mul_share_ctrl_if.sv
// Requester, response and multiplier handshake bundle for mul_share_ctrl.
// The slave modport is the controller; the master modport is its environment
// (integer pipes plus the shared Booth multiplier).
interface mul_share_ctrl_if #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*XLEN-1:0] req_src1;
    logic [N_REQ*XLEN-1:0] req_src2;
    logic [N_REQ-1:0]      req_signed;
    logic [N_REQ-1:0]      req_high;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [XLEN-1:0]       rsp_data;
    logic [XLEN:0]         mul_src1;
    logic [XLEN:0]         mul_src2;
    logic                  mul_in_valid;
    logic                  mul_in_ready;
    logic                  mul_out_valid;
    logic [2*XLEN-1:0]     mul_result;

    modport slave (
        input  req_valid, req_src1, req_src2, req_signed, req_high, rsp_ready,
               mul_in_ready, mul_out_valid, mul_result,
        output req_ready, rsp_valid, rsp_data, mul_src1, mul_src2, mul_in_valid
    );

    modport master (
        output req_valid, req_src1, req_src2, req_signed, req_high, rsp_ready,
               mul_in_ready, mul_out_valid, mul_result,
        input  req_ready, rsp_valid, rsp_data, mul_src1, mul_src2, mul_in_valid
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one iterative multiplier among N_REQ integer pipes.
// One operation in flight; zero operands short-circuit the multiplier.
module mul_share_ctrl #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    mul_share_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] ops_done
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr, owner, grant_idx;
    logic [PTR_W:0]   scan;
    logic             grant_found, high_q;
    logic [N_REQ-1:0] grant_oh, owner_oh, rsp_valid_q;
    logic [XLEN-1:0]  sel_a, sel_b, rsp_data_q;
    logic             sel_signed, sel_high, mul_in_valid_q;
    logic [XLEN:0]    op_a, op_b;

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(N_REQ))
                scan = scan - (PTR_W+1)'(N_REQ);
            if (!grant_found && bus.req_valid[scan[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[PTR_W-1:0];
            end
        end
    end

    assign grant_oh   = ONE << grant_idx;
    assign owner_oh   = ONE << owner;
    assign sel_a      = bus.req_src1[int'(grant_idx)*XLEN +: XLEN];
    assign sel_b      = bus.req_src2[int'(grant_idx)*XLEN +: XLEN];
    assign sel_signed = bus.req_signed[grant_idx];
    assign sel_high   = bus.req_high[grant_idx];

    // Grant is offered only while idle and out of reset.
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && !reset && grant_found)
            bus.req_ready = grant_oh;
    end

    assign bus.mul_src1     = op_a;
    assign bus.mul_src2     = op_b;
    assign bus.mul_in_valid = mul_in_valid_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;

    // Control FSM: accept, issue to multiplier, wait for result, hold response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            high_q         <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            mul_in_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            ops_done       <= '0;
        end else begin
            case (state)
                IDLE: if (grant_found) begin
                    owner  <= grant_idx;
                    high_q <= sel_high;
                    op_a   <= {sel_signed & sel_a[XLEN-1], sel_a};
                    op_b   <= {sel_signed & sel_b[XLEN-1], sel_b};
                    if (sel_a == '0 || sel_b == '0) begin
                        // Product is zero either way; skip the multiplier.
                        rsp_data_q  <= '0;
                        rsp_valid_q <= grant_oh;
                        state       <= RESP;
                    end else begin
                        mul_in_valid_q <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: if (bus.mul_in_ready) begin
                    mul_in_valid_q <= 1'b0;
                    state          <= BUSY;
                end
                BUSY: if (bus.mul_out_valid) begin
                    rsp_data_q  <= high_q ? bus.mul_result[2*XLEN-1:XLEN]
                                          : bus.mul_result[XLEN-1:0];
                    rsp_valid_q <= owner_oh;
                    state       <= RESP;
                end
                RESP: if (bus.rsp_ready[owner]) begin
                    rsp_valid_q <= '0;
                    ops_done    <= ops_done + 1'b1;
                    rr_ptr      <= (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
